// File: rtl/lfsr_multistep.sv
// Multi-step Fibonacci LFSR: run-time taps, seed handshake, lock-up recovery, wrap/period measurement.
// All outputs registered (1 cycle); o_Seed_Ready drops for the single cycle after an accepted seed.
module lfsr_multistep #(
    parameter int               WIDTH        = 32,
    parameter int               STEPS        = 1,
    parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(32'h8020_0003),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
    parameter int               CNT_W        = 32
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Enable,
    input  logic             i_Seed_Valid,
    output logic             o_Seed_Ready,
    input  logic [WIDTH-1:0] i_Seed_Data,
    input  logic             i_Taps_Valid,
    input  logic [WIDTH-1:0] i_Taps_Data,
    output logic [WIDTH-1:0] o_LFSR_Data,
    output logic             o_Valid,
    output logic             o_Lockup,
    output logic             o_Wrap,
    output logic [CNT_W-1:0] o_Period
);
    localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_seed_q, ref_seed_d;
    logic [WIDTH-1:0] taps_q, taps_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q, wrap_d;
    logic             seed_ready_q, seed_ready_d;

    logic [WIDTH-1:0] step_state;
    logic             hit;
    logic [CNT_W-1:0] hit_j;
    logic             load;

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s,
                                                input logic [WIDTH-1:0] t);
        return {s[WIDTH-2:0], ^(s & t)};
    endfunction

    // Unrolled shift chain; the first intermediate equal to the reference seed marks the wrap point.
    always_comb begin
        logic [WIDTH-1:0] s;
        s     = state_q;
        hit   = 1'b0;
        hit_j = '0;
        for (int j = 1; j <= STEPS; j++) begin
            s = shift1(s, taps_q);
            if (!hit && s == ref_seed_q) begin
                hit   = 1'b1;
                hit_j = CNT_W'(j);
            end
        end
        step_state = s;
    end

    always_comb begin
        state_d      = state_q;
        ref_seed_d   = ref_seed_q;
        taps_d       = i_Taps_Valid ? i_Taps_Data : taps_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        valid_d      = 1'b0;
        lockup_d     = 1'b0;
        wrap_d       = 1'b0;
        seed_ready_d = 1'b1;
        load         = i_Seed_Valid && seed_ready_q;

        if (load) begin
            seed_ready_d = 1'b0;
            valid_d      = 1'b1;
            cnt_d        = '0;
            if (i_Seed_Data == '0) begin
                state_d    = DEFAULT_SEED;
                ref_seed_d = DEFAULT_SEED;
                lockup_d   = 1'b1;
            end else begin
                state_d    = i_Seed_Data;
                ref_seed_d = i_Seed_Data;
            end
        end else if (i_Enable) begin
            valid_d = 1'b1;
            if (state_q == '0) begin
                state_d  = DEFAULT_SEED;
                lockup_d = 1'b1;
                cnt_d    = '0;
            end else begin
                state_d = step_state;
                if (hit) begin
                    wrap_d   = 1'b1;
                    period_d = cnt_q + hit_j;
                    cnt_d    = STEPS_C - hit_j;
                end else begin
                    cnt_d = cnt_q + STEPS_C;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= DEFAULT_SEED;
            ref_seed_q   <= DEFAULT_SEED;
            taps_q       <= DEFAULT_TAPS;
            cnt_q        <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            lockup_q     <= 1'b0;
            wrap_q       <= 1'b0;
            seed_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            ref_seed_q   <= ref_seed_d;
            taps_q       <= taps_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            lockup_q     <= lockup_d;
            wrap_q       <= wrap_d;
            seed_ready_q <= seed_ready_d;
        end
    end

    assign o_LFSR_Data  = state_q;
    assign o_Valid      = valid_q;
    assign o_Lockup     = lockup_q;
    assign o_Wrap       = wrap_q;
    assign o_Period     = period_q;
    assign o_Seed_Ready = seed_ready_q;

endmodule
